// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned IMEM_WORDS = 49,
    parameter logic [31:0] NOP_INSTR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_misalign,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic       S_RUN  = 1'b0;
    localparam logic       S_HALT = 1'b1;
    localparam logic [29:0] LIM   = 30'(IMEM_WORDS);

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic        redir;
    logic        oor;
    logic        bub;
    logic        cap;

    assign pc_plus4 = pc_q + 32'd4;
    assign oor      = pc_q[31:2] >= LIM;

    // jump_en is only honoured in RUN and when ID is not stalled
    always_comb begin
        redir = 1'b0;
        tgt   = 32'h0;
        if (branch_taken) begin
            redir = 1'b1;
            tgt   = branch_target;
        end else if (jr_en) begin
            redir = 1'b1;
            tgt   = jr_target;
        end else if (jump_en && !stall && state_q == S_RUN) begin
            redir = 1'b1;
            tgt   = jump_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        bub     = 1'b0;
        cap     = 1'b0;
        if (redir) begin
            pc_d    = tgt & ~32'h3;
            mis_d   = |tgt[1:0];
            state_d = S_RUN;
            bub     = 1'b1;
        end else if (state_q == S_HALT) begin
            bub = 1'b1;
        end else if (oor) begin
            state_d = S_HALT;
            bub     = 1'b1;
        end else begin
            if (!stall)
                pc_d = pc_plus4;
            if (flush)
                bub = 1'b1;
            else if (!stall)
                cap = 1'b1;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bub) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (cap) begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, bcnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fcnt_q <= 32'h0;
            bcnt_q <= 32'h0;
        end else begin
            if (cap)
                fcnt_q <= fcnt_q + 32'd1;
            if (bub)
                bcnt_q <= bcnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt  = fcnt_q;
    assign perf_bubble_cnt = bcnt_q;
`endif

    assign imem_addr      = pc_q;
    assign imem_read      = rst && (state_q == S_RUN);
    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_misalign = mis_q;
    assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expectations queued per driven cycle.
// Build with FETCH_PERF_CNT_EN defined to also exercise the counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        branch_taken, jr_en, jump_en;
    logic [31:0] branch_target, jr_target, jump_target;
    logic [31:0] imem_addr, imem_data, pc;
    logic        imem_read;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, fetch_misalign, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    logic [31:0] mem [64];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic        halt;
        logic        chk_p4;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:2] < 30'd64) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jr_en          (jr_en),
        .jr_target      (jr_target),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .imem_data      (imem_data),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0;
        branch_taken = 0; jr_en = 0; jump_en = 0;
        branch_target = 0; jr_target = 0; jump_target = 0;
    endtask

    task automatic step(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                        input logic [31:0] ep4, input logic ev, input logic em,
                        input logic eh, input logic cp4);
        exp_t e, o;
        e = '{tag, epc, ein, ep4, ev, em, eh, cp4};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({o.tag, ".pc"}, pc, o.pc);
        check({o.tag, ".addr"}, imem_addr, o.pc);
        check({o.tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, o.valid});
        check({o.tag, ".instr"}, if_id_instr, o.instr);
        if (o.chk_p4)
            check({o.tag, ".pc4"}, if_id_pc_plus4, o.pc4);
        check({o.tag, ".mis"}, {31'h0, fetch_misalign}, {31'h0, o.mis});
        check({o.tag, ".halt"}, {31'h0, halted}, {31'h0, o.halt});
    endtask

    // valid fetch shorthand: instruction word at pc-4 captured
    task automatic run(input string tag, input logic [31:0] epc);
        logic [31:0] w;
        w = epc - 32'd4;
        step(tag, epc, mem[w[7:2]], epc, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic bubble(input string tag, input logic [31:0] epc,
                          input logic em, input logic eh);
        step(tag, epc, 32'h0, 32'h0, 1'b0, em, eh, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0C00_0004;
        mem[1] = 32'h8C41_0004;

        idle();
        rst = 1'b0;
        #1;
        check("rd_in_rst", {31'h0, imem_read}, 32'h0);
        step("rst0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rst1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rd_in_rst2", {31'h0, imem_read}, 32'h0);
        rst = 1'b1;
        #1;
        check("rd_run", {31'h0, imem_read}, 32'h1);

        step("t1e1", 32'h4, 32'h0C00_0004, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        step("t1e2", 32'h8, 32'h8C41_0004, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
        run("seq3", 32'hC);
        run("seq4", 32'h10);

        stall = 1;
        step("st1", 32'h10, mem[3], 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        step("st2", 32'h10, mem[3], 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        stall = 0;
        run("st_rel", 32'h14);

        stall = 1; flush = 1;
        bubble("flsh_st", 32'h14, 1'b0, 1'b0);
        idle();
        run("flsh_rel", 32'h18);

        branch_taken = 1; branch_target = 32'h20;
        jump_en = 1; jump_target = 32'h40; stall = 1;
        bubble("br_pri", 32'h20, 1'b0, 1'b0);
        idle();
        run("br_next", 32'h24);

        jr_en = 1; jr_target = 32'h1E;
        bubble("jr_mis", 32'h1C, 1'b1, 1'b0);
        idle();
        run("jr_next", 32'h20);

        jump_en = 1; jump_target = 32'h40;
        bubble("jmp", 32'h40, 1'b0, 1'b0);
        idle();
        run("jmp_next", 32'h44);
        jump_en = 1; jump_target = 32'h80; stall = 1;
        step("jmp_stall", 32'h44, mem[16], 32'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        branch_taken = 1; branch_target = 32'hB8;
        bubble("to_b8", 32'hB8, 1'b0, 1'b0);
        idle();
        run("seq_bc", 32'hBC);
        run("seq_c0", 32'hC0);
        run("seq_c4", 32'hC4);
        bubble("halt", 32'hC4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stall = i[0]; jump_en = ~i[0]; jump_target = 32'h40;
            bubble("halt_hold", 32'hC4, 1'b0, 1'b1);
            check("halt_rd", {31'h0, imem_read}, 32'h0);
        end
        idle();
        branch_taken = 1; branch_target = 32'h0;
        bubble("unhalt", 32'h0, 1'b0, 1'b0);
        idle();
        step("re_e1", 32'h4, 32'h0C00_0004, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        run("re_e2", 32'h8);

        stall = 1; rst = 0;
        step("rst_st", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_f0", perf_fetch_cnt, 32'h0);
        check("perf_b0", perf_bubble_cnt, 32'h0);
`endif
        idle();
        rst = 1;
        step("t6e1", 32'h4, 32'h0C00_0004, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        step("t6e2", 32'h8, 32'h8C41_0004, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_f2", perf_fetch_cnt, 32'h2);
        check("perf_b2", perf_bubble_cnt, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
